// File: rtl/gpu_mem_disagg_arbiter.sv
// Round-robin arbiter feeding the GPU memory byte disaggregator.
// Accepts one 16-byte payload from NREQ requesters, then streams it as
// BEAT_BYTES-wide beats (hi byte of each 16-bit word first) under valid/ready.
module gpu_mem_disagg_arbiter #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned SRC_W      = 1,
    parameter int unsigned BEAT_BYTES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           io_req_valid,
    output logic [NREQ-1:0]           io_req_ready,
    input  logic [NREQ*128-1:0]       io_req_payload,
    output logic                      io_out_valid,
    input  logic                      io_out_ready,
    output logic [8*BEAT_BYTES-1:0]   io_out_data,
    output logic                      io_out_last,
    output logic [SRC_W-1:0]          io_out_src,
    output logic                      io_busy
);

    localparam int unsigned PAY_W  = 128;
    localparam int unsigned BEATS  = 16 / BEAT_BYTES;
    localparam int unsigned DATA_W = 8 * BEAT_BYTES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [SRC_W-1:0]   rr_ptr, rr_nxt;
    logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
    logic [PAY_W-1:0]   latch, latch_nxt;
    logic [SRC_W-1:0]   src_q, src_nxt;

    logic               found;
    logic [SRC_W-1:0]   grant;
    int unsigned        cand;
    logic               accept;
    logic               last_beat;
    logic               drain;
    logic [PAY_W-1:0]   stream;
    logic [DATA_W-1:0]  beat_data;

    // Round-robin search starting at rr_ptr; first valid requester wins
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = 0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            cand = (32'(rr_ptr) + o) % NREQ;
            if (!found && io_req_valid[SRC_W'(cand)]) begin
                found = 1'b1;
                grant = SRC_W'(cand);
            end
        end
    end

    assign drain     = (state == DRAIN);
    assign accept    = (state == IDLE) && found;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

    // Grant is combinational; forced low while reset is held
    assign io_req_ready = (reset && accept) ? (NREQ'(1) << grant) : '0;

    // Swap bytes within each 16-bit word so the stream is hi byte first
    always_comb begin
        stream = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            stream[16*k +: 8]   = latch[16*k+8 +: 8];
            stream[16*k+8 +: 8] = latch[16*k +: 8];
        end
    end

    assign beat_data = DATA_W'(stream >> (32'(beat_cnt) * DATA_W));

    // Next-state and register updates
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        cnt_nxt   = beat_cnt;
        latch_nxt = latch;
        src_nxt   = src_q;
        case (state)
            IDLE: begin
                if (found) begin
                    latch_nxt = PAY_W'(io_req_payload >> (32'(grant) * PAY_W));
                    src_nxt   = grant;
                    cnt_nxt   = '0;
                    rr_nxt    = SRC_W'((32'(grant) + 32'd1) % NREQ);
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (io_out_ready) begin
                    if (last_beat) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            latch    <= '0;
            src_q    <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= cnt_nxt;
            latch    <= latch_nxt;
            src_q    <= src_nxt;
        end
    end

    // Output beat view, zero outside DRAIN
    always_comb begin
        io_out_valid = drain;
        io_busy      = drain;
        io_out_data  = drain ? beat_data : '0;
        io_out_last  = drain && last_beat;
        io_out_src   = drain ? src_q : '0;
    end

endmodule

// File: tb/tb_gpu_mem_disagg_arbiter.sv
// Directed bench for gpu_mem_disagg_arbiter (4-byte and 16-byte beat variants).
module tb_gpu_mem_disagg_arbiter;

    logic         clock;
    logic         reset;

    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [255:0] req_payload;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [0:0]   out_src;
    logic         busy;

    logic [1:0]   req_valid16;
    logic [1:0]   req_ready16;
    logic [255:0] req_payload16;
    logic         out_valid16;
    logic         out_ready16;
    logic [127:0] out_data16;
    logic         out_last16;
    logic [0:0]   out_src16;
    logic         busy16;

    int n_checks;
    int n_errs;

    gpu_mem_disagg_arbiter #(.NREQ(2), .SRC_W(1), .BEAT_BYTES(4)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .io_req_valid   (req_valid),
        .io_req_ready   (req_ready),
        .io_req_payload (req_payload),
        .io_out_valid   (out_valid),
        .io_out_ready   (out_ready),
        .io_out_data    (out_data),
        .io_out_last    (out_last),
        .io_out_src     (out_src),
        .io_busy        (busy)
    );

    gpu_mem_disagg_arbiter #(.NREQ(2), .SRC_W(1), .BEAT_BYTES(16)) u_dut16 (
        .clock          (clock),
        .reset          (reset),
        .io_req_valid   (req_valid16),
        .io_req_ready   (req_ready16),
        .io_req_payload (req_payload16),
        .io_out_valid   (out_valid16),
        .io_out_ready   (out_ready16),
        .io_out_data    (out_data16),
        .io_out_last    (out_last16),
        .io_out_src     (out_src16),
        .io_busy        (busy16)
    );

    // 10-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sample point: 2 units after the falling edge, well clear of the rising edge
    task automatic tick;
        @(negedge clock);
        #2;
    endtask

    // One full payload on the 4-byte DUT: grant check, 4 beats, then IDLE
    task automatic run_payload(input string tag, input logic [1:0] exp_ready, input logic exp_src,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3, input bit drop);
        logic [31:0] d [4];
        d = '{d0, d1, d2, d3};
        #1;
        check({tag, ".grant"}, 128'(req_ready), 128'(exp_ready));
        check({tag, ".idle_valid"}, 128'(out_valid), 128'(0));
        for (int b = 0; b < 4; b++) begin
            tick;
            if (drop && b == 0) req_valid = 2'b00;
            check($sformatf("%s.b%0d.valid", tag, b), 128'(out_valid), 128'(1));
            check($sformatf("%s.b%0d.data", tag, b), 128'(out_data), 128'(d[b]));
            check($sformatf("%s.b%0d.last", tag, b), 128'(out_last), 128'(b == 3));
            check($sformatf("%s.b%0d.src", tag, b), 128'(out_src), 128'(exp_src));
            check($sformatf("%s.b%0d.ready", tag, b), 128'(req_ready), 128'(0));
            check($sformatf("%s.b%0d.busy", tag, b), 128'(busy), 128'(1));
        end
        tick;
        check({tag, ".end_valid"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        n_checks      = 0;
        n_errs        = 0;
        reset         = 1'b0;
        req_valid     = 2'b11;
        req_payload   = '0;
        out_ready     = 1'b1;
        req_valid16   = 2'b00;
        req_payload16 = '0;
        out_ready16   = 1'b1;

        // Reset state: all outputs low even with requests pending
        #3;
        check("rst.ready", 128'(req_ready), 128'(0));
        check("rst.valid", 128'(out_valid), 128'(0));
        check("rst.data", 128'(out_data), 128'(0));
        check("rst.last", 128'(out_last), 128'(0));
        check("rst.src", 128'(out_src), 128'(0));
        check("rst.busy", 128'(busy), 128'(0));
        tick;
        tick;
        reset = 1'b1;

        // Test 1: req0 only, words 0x1234, 0x5678, then zeros
        req_valid          = 2'b01;
        req_payload[127:0] = 128'h0000_0000_0000_0000_0000_0000_5678_1234;
        run_payload("t1", 2'b01, 1'b0, 32'h7856_3412, 32'h0, 32'h0, 32'h0, 1'b1);
        check("t1.no_regrant", 128'(req_ready), 128'(0));

        // Test 5: req1 alone, held valid, granted on every IDLE visit
        req_valid            = 2'b10;
        req_payload[255:128] = {8{16'hC1D1}};
        run_payload("t5a", 2'b10, 1'b1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 1'b0);
        run_payload("t5b", 2'b10, 1'b1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 1'b0);

        // Test 2: both requesters held valid, strict alternation starting at 0
        req_valid          = 2'b11;
        req_payload[127:0] = {8{16'hA0B0}};
        run_payload("t2a", 2'b01, 1'b0, 32'hB0A0_B0A0, 32'hB0A0_B0A0, 32'hB0A0_B0A0, 32'hB0A0_B0A0, 1'b0);
        run_payload("t2b", 2'b10, 1'b1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 1'b0);
        run_payload("t2c", 2'b01, 1'b0, 32'hB0A0_B0A0, 32'hB0A0_B0A0, 32'hB0A0_B0A0, 32'hB0A0_B0A0, 1'b0);
        run_payload("t2d", 2'b10, 1'b1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 32'hD1C1_D1C1, 1'b0);
        req_valid = 2'b00;
        tick;

        // Test 3: downstream stall for 3 cycles on beat 2
        req_payload[127:0] = 128'hEEFF_CCDD_AABB_8899_6677_4455_2233_0011;
        req_valid          = 2'b01;
        #1;
        check("t3.grant", 128'(req_ready), 128'(2'b01));
        tick;
        req_valid = 2'b00;
        check("t3.b0.data", 128'(out_data), 128'(32'h3322_1100));
        tick;
        check("t3.b1.data", 128'(out_data), 128'(32'h7766_5544));
        tick;
        check("t3.b2.data", 128'(out_data), 128'(32'hBBAA_9988));
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick;
            check($sformatf("t3.stall%0d.valid", s), 128'(out_valid), 128'(1));
            check($sformatf("t3.stall%0d.data", s), 128'(out_data), 128'(32'hBBAA_9988));
            check($sformatf("t3.stall%0d.last", s), 128'(out_last), 128'(0));
        end
        out_ready = 1'b1;
        tick;
        check("t3.b3.data", 128'(out_data), 128'(32'hFFEE_DDCC));
        check("t3.b3.last", 128'(out_last), 128'(1));
        tick;
        check("t3.end_valid", 128'(out_valid), 128'(0));

        // Test 4: async reset in beat 1 aborts the drain and clears rr_ptr
        req_valid = 2'b01;
        #1;
        check("t4.grant", 128'(req_ready), 128'(2'b01));
        tick;
        req_valid = 2'b00;
        tick;
        check("t4.b1.data", 128'(out_data), 128'(32'h7766_5544));
        #1;
        reset     = 1'b0;
        req_valid = 2'b11;
        #1;
        check("t4.rst.valid", 128'(out_valid), 128'(0));
        check("t4.rst.data", 128'(out_data), 128'(0));
        check("t4.rst.last", 128'(out_last), 128'(0));
        check("t4.rst.busy", 128'(busy), 128'(0));
        check("t4.rst.ready", 128'(req_ready), 128'(0));
        tick;
        reset = 1'b1;
        run_payload("t4", 2'b01, 1'b0, 32'h3322_1100, 32'h7766_5544, 32'hBBAA_9988, 32'hFFEE_DDCC, 1'b1);

        // Test 6: 16-byte beats, whole payload in a single last beat
        req_payload16[127:0] = 128'h0F10_0D0E_0B0C_090A_0708_0506_0304_0102;
        req_valid16          = 2'b01;
        #1;
        check("t6.grant", 128'(req_ready16), 128'(2'b01));
        check("t6.idle_valid", 128'(out_valid16), 128'(0));
        tick;
        req_valid16 = 2'b00;
        check("t6.valid", 128'(out_valid16), 128'(1));
        check("t6.data", out_data16, 128'h100F_0E0D_0C0B_0A09_0807_0605_0403_0201);
        check("t6.last", 128'(out_last16), 128'(1));
        check("t6.src", 128'(out_src16), 128'(0));
        check("t6.busy", 128'(busy16), 128'(1));
        tick;
        check("t6.end_valid", 128'(out_valid16), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
